// File: rtl/fb_pkg.sv
// Shared types for the framebuffer update scheduler.
// State encoding, mode codes and framebuffer address width.
package fb_pkg;

  localparam int FB_AW = 19;
  localparam int FB_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_STABLE,
    ST_WAIT_VBLANK,
    ST_RESTART,
    ST_CLEAR,
    ST_COPY
  } fb_state_e;

  localparam logic [3:0] MODE_REPL     = 4'h0;
  localparam logic [3:0] MODE_DECIM    = 4'h1;
  localparam logic [3:0] MODE_NN       = 4'h2;
  localparam logic [3:0] MODE_REPL_4X  = 4'h3;
  localparam logic [3:0] MODE_DECIM_4X = 4'h4;
  localparam logic [3:0] MODE_NN_4X    = 4'h5;

endpackage

// File: rtl/sync_stable_detect.sv
// 2-flop synchronizer plus a saturating stability counter.
// stable rises once din has held for STABLE_CYCLES counted cycles.
module sync_stable_detect #(
  parameter int unsigned W             = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] dout,
  output logic         stable
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

  logic [W-1:0]  s1_q, s1_d;
  logic [W-1:0]  s2_q, s2_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          changed;

  // Sync chain shift, change detect and saturating count
  always_comb begin
    s1_d    = din;
    s2_d    = s1_q;
    prev_d  = s2_q;
    changed = (s2_q != prev_q);
    cnt_d   = cnt_q;
    if (clr || changed)
      cnt_d = '0;
    else if (en && (cnt_q != CMAX))
      cnt_d = cnt_q + 1'b1;
    dout   = s2_q;
    stable = en && !changed && (cnt_q == CMAX);
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fb_update_scheduler.sv
// Commits switch mode changes at vblank, restarts the copier, arbitrates RAM.
// Define FB_CLEAR_EN to zero the framebuffer between restart and copy.
module fb_update_scheduler
  import fb_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 4000000,
  parameter int unsigned FB_DEPTH       = 307200
) (
  input  logic             clk_50MHz,
  input  logic             vga_reset,
  input  logic [3:0]       sw,
  input  logic             vsync_n,
  input  logic             copy_done,
  input  logic [FB_AW-1:0] cp_wraddr,
  input  logic [FB_DW-1:0] cp_wrdata,
  input  logic             cp_wren,
  input  logic             hps_req,
  input  logic [FB_AW-1:0] hps_addr,
  input  logic [FB_DW-1:0] hps_data,
  output logic [3:0]       seletor_out,
  output logic             copier_rst_n,
  output logic             display_en,
  output logic [FB_AW-1:0] ram_wraddr,
  output logic [FB_DW-1:0] ram_data,
  output logic             ram_wren,
  output logic             hps_gnt,
  output logic             busy,
  output logic             err_timeout
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  fb_state_e     state_q, state_d;
  logic [3:0]    sel_q, sel_d;
  logic          disp_q, disp_d;
  logic          pend_q, pend_d;
  logic          armed_q, armed_d;
  logic          abort_q, abort_d;
  logic          err_q, err_d;
  logic [1:0]    rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    vs_q, vs_d;
  logic          vs_fall;
  logic [3:0]    sw_s;
  logic          sw_stable;

`ifdef FB_CLEAR_EN
  localparam int AW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam logic [AW-1:0] AMAX = AW'(FB_DEPTH - 1);
  logic [AW-1:0] caddr_q, caddr_d;
`endif

  sync_stable_detect #(
    .W             (4),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sw_sync (
    .clk    (clk_50MHz),
    .rst_n  (vga_reset),
    .din    (sw),
    .en     (state_q == ST_WAIT_STABLE),
    .clr    (state_q != ST_WAIT_STABLE),
    .dout   (sw_s),
    .stable (sw_stable)
  );

  // Next-state, counters and display blanking control
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    armed_d = 1'b0;
    abort_d = 1'b0;
    err_d   = err_q;
    rcnt_d  = '0;
    tcnt_d  = '0;
`ifdef FB_CLEAR_EN
    caddr_d = '0;
`endif
    vs_d    = {vs_q[1:0], vsync_n};
    vs_fall = vs_q[2] & ~vs_q[1];
    if (pend_q && vs_fall) begin
      disp_d = 1'b1;
      pend_d = 1'b0;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (sw_s != sel_q)
          state_d = ST_WAIT_STABLE;
      end
      ST_WAIT_STABLE: begin
        if (sw_s == sel_q)
          state_d = ST_IDLE;
        else if (sw_stable)
          state_d = ST_WAIT_VBLANK;
      end
      ST_WAIT_VBLANK: begin
        if (vs_fall) begin
          sel_d   = sw_s;
          disp_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_RESTART;
        end
      end
      ST_RESTART: begin
        if (rcnt_q == 2'd3)
`ifdef FB_CLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_COPY;
`endif
        else
          rcnt_d = rcnt_q + 2'd1;
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        if (caddr_q == AMAX)
          state_d = ST_COPY;
        else
          caddr_d = caddr_q + 1'b1;
      end
`endif
      ST_COPY: begin
        armed_d = armed_q | ~copy_done;
        if (armed_q && copy_done) begin
          state_d = ST_IDLE;
          pend_d  = 1'b1;
        end else if (tcnt_q == TMAX) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          abort_d = 1'b1;
          disp_d  = 1'b1;
          pend_d  = 1'b0;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // RAM port arbitration and status outputs
  always_comb begin
    ram_wraddr   = '0;
    ram_data     = '0;
    ram_wren     = 1'b0;
    hps_gnt      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ram_wraddr = hps_addr;
        ram_data   = hps_data;
        ram_wren   = hps_req;
        hps_gnt    = hps_req;
      end
      ST_COPY: begin
        ram_wraddr = cp_wraddr;
        ram_data   = cp_wrdata;
        ram_wren   = cp_wren;
      end
`ifdef FB_CLEAR_EN
      ST_CLEAR: begin
        ram_wraddr = FB_AW'(caddr_q);
        ram_wren   = 1'b1;
      end
`endif
      default: ;
    endcase
    copier_rst_n = ~abort_q
                 & (state_q != ST_RESTART)
                 & (state_q != ST_CLEAR);
    seletor_out  = sel_q;
    display_en   = disp_q;
    busy         = (state_q != ST_IDLE);
    err_timeout  = err_q;
  end

  // State registers; reset lands in RESTART to load mode 0
  always_ff @(posedge clk_50MHz or negedge vga_reset) begin
    if (!vga_reset) begin
      state_q <= ST_RESTART;
      sel_q   <= '0;
      disp_q  <= 1'b0;
      pend_q  <= 1'b0;
      armed_q <= 1'b0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      vs_q    <= '0;
`ifdef FB_CLEAR_EN
      caddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      tcnt_q  <= tcnt_d;
      vs_q    <= vs_d;
`ifdef FB_CLEAR_EN
      caddr_q <= caddr_d;
`endif
    end
  end

endmodule

// File: tb/tb_fb_update_scheduler.sv
// Directed bench for fb_update_scheduler.
// Reduced parameters: 16 stable cycles, 64 timeout cycles, 32-word framebuffer.
module tb_fb_update_scheduler;

  localparam int FBD = 32;
`ifdef FB_CLEAR_EN
  localparam int CLR_N = FBD;
`else
  localparam int CLR_N = 0;
`endif

  logic        clk = 1'b0;
  logic        vga_reset;
  logic [3:0]  sw;
  logic        vsync_n;
  logic        copy_done;
  logic [18:0] cp_wraddr;
  logic [7:0]  cp_wrdata;
  logic        cp_wren;
  logic        hps_req;
  logic [18:0] hps_addr;
  logic [7:0]  hps_data;
  logic [3:0]  seletor_out;
  logic        copier_rst_n;
  logic        display_en;
  logic [18:0] ram_wraddr;
  logic [7:0]  ram_data;
  logic        ram_wren;
  logic        hps_gnt;
  logic        busy;
  logic        err_timeout;

  int checks = 0;
  int errors = 0;

  fb_update_scheduler #(
    .STABLE_CYCLES  (16),
    .TIMEOUT_CYCLES (64),
    .FB_DEPTH       (FBD)
  ) dut (
    .clk_50MHz    (clk),
    .vga_reset    (vga_reset),
    .sw           (sw),
    .vsync_n      (vsync_n),
    .copy_done    (copy_done),
    .cp_wraddr    (cp_wraddr),
    .cp_wrdata    (cp_wrdata),
    .cp_wren      (cp_wren),
    .hps_req      (hps_req),
    .hps_addr     (hps_addr),
    .hps_data     (hps_data),
    .seletor_out  (seletor_out),
    .copier_rst_n (copier_rst_n),
    .display_en   (display_en),
    .ram_wraddr   (ram_wraddr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .hps_gnt      (hps_gnt),
    .busy         (busy),
    .err_timeout  (err_timeout)
  );

  always #10 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts cycles with the copier held in reset, tracking clear writes.
  task automatic count_rst_low(output int n, output int nwr, output int bad);
    n = 0; nwr = 0; bad = 0;
    while (copier_rst_n === 1'b0 && n < 200) begin
      if (ram_wren === 1'b1) begin
        if (ram_wraddr !== 19'(nwr) || ram_data !== 8'h00) bad++;
        nwr++;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rst_low(output bit ok);
    int n = 0;
    while (copier_rst_n !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (copier_rst_n === 1'b0);
  endtask

  task automatic test_reset;
    vga_reset = 1'b0; sw = 4'h0; vsync_n = 1'b1; copy_done = 1'b0;
    cp_wraddr = '0; cp_wrdata = '0; cp_wren = 1'b0;
    hps_req = 1'b1; hps_addr = 19'h00011; hps_data = 8'h22;
    tick(3);
    checks++; if (seletor_out !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h want 0", seletor_out); end
    checks++; if (copier_rst_n !== 1'b0) begin errors++; $display("FAIL reset_cprst: got %b want 0", copier_rst_n); end
    checks++; if (display_en !== 1'b0) begin errors++; $display("FAIL reset_disp: got %b want 0", display_en); end
    checks++; if (ram_wren !== 1'b0 || hps_gnt !== 1'b0) begin errors++; $display("FAIL reset_port: wren %b gnt %b want 0 0", ram_wren, hps_gnt); end
    checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset_status: busy %b err %b want 1 0", busy, err_timeout); end
    hps_req = 1'b0;
  endtask

  task automatic test_powerup;
    int n, nwr, bad;
    vga_reset = 1'b1;
    count_rst_low(n, nwr, bad);
    checks++; if (n !== 4 + CLR_N) begin errors++; $display("FAIL pwr_rst_len: got %0d want %0d", n, 4 + CLR_N); end
    checks++; if (nwr !== CLR_N || bad !== 0) begin errors++; $display("FAIL pwr_clear: writes %0d bad %0d want %0d 0", nwr, bad, CLR_N); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pwr_copy: busy %b want 1", busy); end
    tick(40);
    copy_done = 1'b1;
    tick(1);
    copy_done = 1'b0;
    checks++; if (busy !== 1'b0 || seletor_out !== 4'h0) begin errors++; $display("FAIL pwr_done: busy %b sel %h want 0 0", busy, seletor_out); end
    tick(5);
    checks++; if (display_en !== 1'b0) begin errors++; $display("FAIL pwr_no_unblank: got %b want 0", display_en); end
    vsync_n = 1'b0;
    tick(4);
    vsync_n = 1'b1;
    checks++; if (display_en !== 1'b1) begin errors++; $display("FAIL pwr_unblank: got %b want 1", display_en); end
    tick(4);
  endtask

  task automatic test_hps_idle;
    hps_req = 1'b1; hps_addr = 19'h12345; hps_data = 8'hAB;
    #1;
    checks++; if (hps_gnt !== 1'b1 || ram_wren !== 1'b1) begin errors++; $display("FAIL hps_idle_gnt: gnt %b wren %b want 1 1", hps_gnt, ram_wren); end
    checks++; if (ram_wraddr !== 19'h12345 || ram_data !== 8'hAB) begin errors++; $display("FAIL hps_idle_data: addr %h data %h want 12345 ab", ram_wraddr, ram_data); end
    hps_req = 1'b0;
    #1;
    checks++; if (hps_gnt !== 1'b0 || ram_wren !== 1'b0) begin errors++; $display("FAIL hps_idle_off: gnt %b wren %b want 0 0", hps_gnt, ram_wren); end
    tick(1);
  endtask

  task automatic test_bounce;
    int lows = 0;
    bit saw_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw = i[0] ? 4'h0 : 4'h2;
      repeat (5) begin
        @(negedge clk);
        if (busy === 1'b1) saw_busy = 1'b1;
        if (copier_rst_n !== 1'b1) lows++;
      end
    end
    repeat (30) begin
      @(negedge clk);
      if (copier_rst_n !== 1'b1) lows++;
    end
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL bounce_enter: busy seen %b want 1", saw_busy); end
    checks++; if (busy !== 1'b0 || seletor_out !== 4'h0) begin errors++; $display("FAIL bounce_idle: busy %b sel %h want 0 0", busy, seletor_out); end
    checks++; if (lows !== 0) begin errors++; $display("FAIL bounce_rst: copier reset cycles %0d want 0", lows); end
  endtask

  task automatic test_mode_change;
    int n, nwr, bad;
    bit ok;
    sw = 4'h2;
    tick(40);
    checks++; if (seletor_out !== 4'h0 || busy !== 1'b1) begin errors++; $display("FAIL mode_pre: sel %h busy %b want 0 1", seletor_out, busy); end
    checks++; if (copier_rst_n !== 1'b1 || display_en !== 1'b1) begin errors++; $display("FAIL mode_pre_out: cprst %b disp %b want 1 1", copier_rst_n, display_en); end
    vsync_n = 1'b0;
    wait_rst_low(ok);
    vsync_n = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mode_restart: copier reset seen %b want 1", ok); end
    checks++; if (seletor_out !== 4'h2 || display_en !== 1'b0) begin errors++; $display("FAIL mode_commit: sel %h disp %b want 2 0", seletor_out, display_en); end
    count_rst_low(n, nwr, bad);
    checks++; if (n !== 4 + CLR_N) begin errors++; $display("FAIL mode_rst_len: got %0d want %0d", n, 4 + CLR_N); end
    checks++; if (nwr !== CLR_N || bad !== 0) begin errors++; $display("FAIL mode_clear: writes %0d bad %0d want %0d 0", nwr, bad, CLR_N); end
    hps_req = 1'b1; hps_addr = 19'h12345; hps_data = 8'hAB;
    cp_wraddr = 19'h00777; cp_wrdata = 8'h5C; cp_wren = 1'b1;
    #1;
    checks++; if (busy !== 1'b1 || hps_gnt !== 1'b0) begin errors++; $display("FAIL copy_gnt: busy %b gnt %b want 1 0", busy, hps_gnt); end
    checks++; if (ram_wren !== 1'b1 || ram_wraddr !== 19'h00777 || ram_data !== 8'h5C) begin errors++; $display("FAIL copy_port: wren %b addr %h data %h want 1 00777 5c", ram_wren, ram_wraddr, ram_data); end
    hps_req = 1'b0; cp_wren = 1'b0;
    tick(5);
    copy_done = 1'b1;
    tick(1);
    copy_done = 1'b0;
    checks++; if (busy !== 1'b0 || display_en !== 1'b0) begin errors++; $display("FAIL mode_done: busy %b disp %b want 0 0", busy, display_en); end
    vsync_n = 1'b0;
    tick(4);
    vsync_n = 1'b1;
    checks++; if (display_en !== 1'b1) begin errors++; $display("FAIL mode_unblank: got %b want 1", display_en); end
    tick(4);
  endtask

  task automatic test_timeout;
    int n, nwr, bad;
    bit ok;
    copy_done = 1'b1;
    sw = 4'h1;
    tick(40);
    vsync_n = 1'b0;
    wait_rst_low(ok);
    vsync_n = 1'b1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_restart: copier reset seen %b want 1", ok); end
    count_rst_low(n, nwr, bad);
    n = 0;
    while (err_timeout !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL tmo_cycle: err after %0d cycles want 64", n); end
    checks++; if (busy !== 1'b0 || display_en !== 1'b1) begin errors++; $display("FAIL tmo_state: busy %b disp %b want 0 1", busy, display_en); end
    checks++; if (copier_rst_n !== 1'b0) begin errors++; $display("FAIL tmo_abort: cprst %b want 0", copier_rst_n); end
    tick(1);
    checks++; if (copier_rst_n !== 1'b1 || err_timeout !== 1'b1) begin errors++; $display("FAIL tmo_after: cprst %b err %b want 1 1", copier_rst_n, err_timeout); end
    checks++; if (seletor_out !== 4'h1) begin errors++; $display("FAIL tmo_sel: got %h want 1", seletor_out); end
    copy_done = 1'b0;
    tick(4);
  endtask

  task automatic test_reset_midcopy;
    int n, nwr, bad;
    bit ok;
    sw = 4'h0;
    tick(40);
    vsync_n = 1'b0;
    wait_rst_low(ok);
    vsync_n = 1'b1;
    count_rst_low(n, nwr, bad);
    tick(10);
    checks++; if (busy !== 1'b1 || copier_rst_n !== 1'b1) begin errors++; $display("FAIL mid_copy: busy %b cprst %b want 1 1", busy, copier_rst_n); end
    vga_reset = 1'b0;
    #1;
    checks++; if (copier_rst_n !== 1'b0 || display_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_reset: cprst %b disp %b busy %b want 0 0 1", copier_rst_n, display_en, busy); end
    checks++; if (err_timeout !== 1'b0 || seletor_out !== 4'h0) begin errors++; $display("FAIL mid_reset_regs: err %b sel %h want 0 0", err_timeout, seletor_out); end
    tick(2);
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_hps_idle();
    test_bounce();
    test_mode_change();
    test_timeout();
    test_reset_midcopy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_update_scheduler.md
FB_UPDATE_SCHEDULER -- requirements
Module: fb_update_scheduler

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000000, meaning the clock count for which sw must hold unchanged before it is committed (20 ms).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4000000, meaning the maximum number of cycles spent in COPY before the copy is aborted.
REQ-003 SHALL have parameter FB_DEPTH, default 307200, meaning the number of framebuffer words.
REQ-004 clk_50MHz  in  1  system clock; all logic is on its rising edge.
REQ-005 vga_reset  in  1  reset, asynchronous, active-low.
REQ-006 sw  in  4  raw mode selector from the board switches.
REQ-007 vsync_n  in  1  VGA vsync, active-low.
REQ-008 copy_done  in  1  copier completion level.
REQ-009 cp_wraddr, cp_wrdata, cp_wren  in  19/8/1  copier write port.
REQ-010 hps_req, hps_addr, hps_data  in  1/19/8  HPS direct-write request.
REQ-011 seletor_out  out  4  committed mode driven to the copier and to the geometry logic.
REQ-012 copier_rst_n  out  1  copier reset, active-low.
REQ-013 display_en  out  1  1 = show framebuffer; 0 = force black.
REQ-014 ram_wraddr, ram_data, ram_wren  out  19/8/1  arbitrated framebuffer write port.
REQ-015 hps_gnt  out  1  HPS write accepted this cycle.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 err_timeout  out  1  sticky copy-timeout flag.

Function
REQ-018 SHALL pass sw and vsync_n each through a 2-flop synchronizer before any use.
REQ-019 SHALL implement the states IDLE, WAIT_STABLE, WAIT_VBLANK, RESTART, CLEAR, COPY.
REQ-020 IDLE: when synchronized sw differs from seletor_out, SHALL go to WAIT_STABLE and clear the stability counter.
REQ-021 WAIT_STABLE: any sw change SHALL restart the counter; when the counter reaches STABLE_CYCLES-1, SHALL go to WAIT_VBLANK; if sw returns to seletor_out, SHALL go back to IDLE.
REQ-022 WAIT_VBLANK: on the falling edge of synchronized vsync_n, SHALL latch sw into seletor_out, drive display_en=0, and go to RESTART.
REQ-023 RESTART: SHALL hold copier_rst_n=0 for exactly 4 cycles, then go to CLEAR (or straight to COPY, per REQ-033).
REQ-024 CLEAR: SHALL write data 0 to addresses 0..FB_DEPTH-1, one per cycle with ram_wren=1, holding the copier in reset, then go to COPY.
REQ-025 COPY: SHALL release copier_rst_n, route the copier port to the RAM port, and arm completion detection only after copy_done has been sampled low at least once.
REQ-026 COPY: on a subsequent copy_done=1, SHALL go to IDLE and set display_en=1 at the next falling edge of vsync_n (no mid-frame unblank).
REQ-027 COPY timeout: after TIMEOUT_CYCLES cycles, SHALL set err_timeout, drive copier_rst_n=0 for 1 cycle, restore display_en=1, and go to IDLE.
REQ-028 Write arbitration: in CLEAR, the scheduler owns the RAM port; in COPY, the copier owns it; in IDLE, HPS owns it with hps_gnt=hps_req, combinational in the same cycle; in all other states, hps_gnt=0 and ram_wren=0.
REQ-029 An sw change during RESTART, CLEAR or COPY SHALL NOT abort the sequence; it SHALL be re-evaluated on return to IDLE.
REQ-030 The counters SHALL be sized by $clog2 of their parameter and SHALL saturate, never wrap.

Reset
REQ-031 On vga_reset=0: state=RESTART, seletor_out=0, copier_rst_n=0, display_en=0, ram_wren=0, hps_gnt=0, busy=1, err_timeout=0, all counters 0, synchronizers cleared.
REQ-032 After release, the block SHALL run RESTART -> [CLEAR] -> COPY for mode 0, so that the power-up image is loaded automatically; reset mid-copy SHALL abort immediately with these same values.

Configuration
REQ-033 Macro FB_CLEAR_EN: when defined, the CLEAR state exists as per REQ-024; when undefined, RESTART goes directly to COPY, no clear logic is synthesized, and the unwritten framebuffer areas keep stale data.

Structure
REQ-034 The shared package fb_pkg SHALL hold the state enum, the mode codes (replication, decimation, nearest-neighbour and their 4x variants), and the FB address width of 19.
REQ-035 SHALL contain one sub-module, sync_stable_detect (2-flop synchronizer plus stability counter), instantiated for sw.

Verification
REQ-036 Reset release, copy_done pulsed 200 cycles into COPY -> seletor_out=0, display_en=1 at the next vsync fall, busy=0.
REQ-037 sw 0000->0010 held for STABLE_CYCLES (reduced to 16 in the bench) -> seletor_out=0010 only at the vsync fall; copier_rst_n low for 4 cycles; COPY entered.
REQ-038 sw bouncing 0010/0000 every 5 cycles for 100 cycles, then stable at 0000 -> returns to IDLE; seletor_out unchanged; no copier reset.
REQ-039 copy_done held at 1 throughout COPY -> no completion until it is seen low and then high; with TIMEOUT_CYCLES=64 -> err_timeout=1 at cycle 64, state=IDLE.
REQ-040 hps_req=1 in IDLE with addr 0x12345, data 0xAB -> same-cycle ram_wren=1, ram_wraddr=0x12345, hps_gnt=1; the same request during COPY -> hps_gnt=0 and the copier data appears on the port.
REQ-041 FB_CLEAR_EN defined, FB_DEPTH=32 -> exactly 32 writes of 0 to addresses 0..31 before COPY.
